// File: rtl/hologram_pkg.sv
// Shared constants for the hologram display path: strip geometry, texture layout,
// pixel/channel packing and the column prefetch state encoding.
package hologram_pkg;

    localparam int LED_COUNT  = 52;
    localparam int TEX_WIDTH  = 64;
    localparam int NUM_FRAMES = 30;
    localparam int FRAME_SIZE = LED_COUNT * TEX_WIDTH;

    localparam int PIX_W  = 24;
    localparam int CH_W   = 8;
    localparam int NUM_CH = 3;
    localparam int G_LSB  = 16;
    localparam int R_LSB  = 8;
    localparam int B_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } fetch_state_t;

    // Channel 0 is blue, 1 is red, 2 is green, matching the {G,R,B} word layout.
    function automatic int ch_lsb(input int ch);
        return (ch == 0) ? B_LSB : ((ch == 1) ? R_LSB : G_LSB);
    endfunction

endpackage

// File: rtl/pixel_bank.sv
// Two-bank column store: one write port aimed at the back bank and one
// registered read port on the front bank; small enough for distributed RAM.
module pixel_bank #(
    parameter int DEPTH = 52,
    parameter int WIDTH = 24,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic             wr_bank,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_bank,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] bank_rd [2];

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_bank
        logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (wr_en && (wr_bank == 1'(gi))) begin
                mem[wr_addr] <= wr_data;
            end
        end

        assign bank_rd[gi] = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        rd_data <= bank_rd[rd_bank];
    end

endmodule

// File: rtl/column_prefetch.sv
// Double-buffered column cache: streams one texture column into the back bank on
// every theta/frame change and swaps it to the front only at a strip wrap.
module column_prefetch #(
    parameter int LED_COUNT  = hologram_pkg::LED_COUNT,
    parameter int TEX_WIDTH  = hologram_pkg::TEX_WIDTH,
    parameter int NUM_FRAMES = hologram_pkg::NUM_FRAMES,
    parameter int ADDR_WIDTH = $clog2(LED_COUNT * TEX_WIDTH * NUM_FRAMES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            theta,
    input  logic [7:0]            frame_idx,
    input  logic [1:0]            brightness,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [23:0]           rom_data,
    input  logic [5:0]            next_px_num,
    output logic [23:0]           pixel,
    output logic                  busy,
    output logic [5:0]            front_col
);

    import hologram_pkg::PIX_W;
    import hologram_pkg::CH_W;
    import hologram_pkg::NUM_CH;
    import hologram_pkg::ch_lsb;
    import hologram_pkg::fetch_state_t;
    import hologram_pkg::ST_IDLE;
    import hologram_pkg::ST_FETCH;
    import hologram_pkg::ST_DRAIN;

    localparam int IDX_W       = $clog2(LED_COUNT);
    localparam int FRAME_WORDS = LED_COUNT * TEX_WIDTH;

    fetch_state_t          state_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [5:0]            last_theta_reg;
    logic [7:0]            last_frame_reg;
    logic                  pending_reg;
    logic                  back_valid_reg;
    logic                  busy_reg;
    logic [ADDR_WIDTH-1:0] rom_addr_reg;
    logic                  wr_en_reg;
    logic [IDX_W-1:0]      wr_idx_reg;
    logic                  bank_sel_reg;
    logic                  front_valid_reg;
    logic [5:0]            front_col_reg;
    logic [5:0]            prev_px_reg;
    logic                  gate_reg;
    logic [1:0]            shift_reg;

    logic                  trigger;
    logic                  wrap;
    logic                  do_swap;
    logic                  front_sel_next;
    logic                  front_valid_next;
    logic                  in_range;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      idx_inc;
    logic [PIX_W-1:0]      bank_q;

    function automatic logic [ADDR_WIDTH-1:0] tex_addr(input logic [7:0]       frame,
                                                       input logic [5:0]       col,
                                                       input logic [IDX_W-1:0] row);
        return ADDR_WIDTH'(frame) * ADDR_WIDTH'(FRAME_WORDS)
             + ADDR_WIDTH'(row) * ADDR_WIDTH'(TEX_WIDTH)
             + ADDR_WIDTH'(col);
    endfunction

    // The read port looks at the post-swap bank so index 0 of a new strip frame
    // already comes from the freshly swapped column.
    always_comb begin
        trigger          = (theta != last_theta_reg) || (frame_idx != last_frame_reg) || pending_reg;
        wrap             = (next_px_num == '0) && (prev_px_reg != '0);
        do_swap          = wrap && back_valid_reg;
        front_sel_next   = bank_sel_reg ^ do_swap;
        front_valid_next = front_valid_reg || do_swap;
        in_range         = 32'(next_px_num) < LED_COUNT;
        rd_idx           = in_range ? IDX_W'(next_px_num) : '0;
        idx_inc          = idx_reg + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            last_theta_reg <= '0;
            last_frame_reg <= '0;
            pending_reg    <= 1'b1;
            back_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            rom_addr_reg   <= '0;
            wr_en_reg      <= 1'b0;
            wr_idx_reg     <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (trigger) begin
                        state_reg      <= ST_FETCH;
                        last_theta_reg <= theta;
                        last_frame_reg <= frame_idx;
                        pending_reg    <= 1'b0;
                        back_valid_reg <= 1'b0;
                        idx_reg        <= '0;
                        busy_reg       <= 1'b1;
                        rom_addr_reg   <= tex_addr(frame_idx, theta, '0);
                    end
                end
                ST_FETCH: begin
                    // ROM answers one cycle later, so the write trails the address by one.
                    wr_en_reg  <= 1'b1;
                    wr_idx_reg <= idx_reg;
                    if (idx_reg == IDX_W'(LED_COUNT - 1)) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        idx_reg      <= idx_inc;
                        rom_addr_reg <= tex_addr(last_frame_reg, last_theta_reg, idx_inc);
                    end
                end
                ST_DRAIN: begin
                    state_reg      <= ST_IDLE;
                    busy_reg       <= 1'b0;
                    back_valid_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
            if (do_swap) begin
                back_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_sel_reg    <= 1'b0;
            front_valid_reg <= 1'b0;
            front_col_reg   <= '0;
            prev_px_reg     <= '0;
            gate_reg        <= 1'b0;
            shift_reg       <= '0;
        end else begin
            prev_px_reg <= next_px_num;
            if (do_swap) begin
                bank_sel_reg    <= ~bank_sel_reg;
                front_valid_reg <= 1'b1;
                front_col_reg   <= last_theta_reg;
            end
            gate_reg  <= front_valid_next && in_range;
            shift_reg <= brightness;
        end
    end

    pixel_bank #(
        .DEPTH(LED_COUNT),
        .WIDTH(PIX_W),
        .AW   (IDX_W)
    ) u_bank (
        .clk    (clk),
        .wr_en  (wr_en_reg),
        .wr_bank(~bank_sel_reg),
        .wr_addr(wr_idx_reg),
        .wr_data(rom_data),
        .rd_bank(front_sel_next),
        .rd_addr(rd_idx),
        .rd_data(bank_q)
    );

    genvar gi;
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
        localparam int LSB = ch_lsb(gi);
        assign pixel[LSB +: CH_W] = gate_reg ? (bank_q[LSB +: CH_W] >> shift_reg) : '0;
    end

    assign rom_addr  = rom_addr_reg;
    assign busy      = busy_reg;
    assign front_col = front_col_reg;

endmodule
